// File: rtl/f_add_resp_checker.sv
// Response monitor for a 1-bit full adder: scores each presented vector against the
// golden result, keeps run statistics, and reports a pass/fail verdict or a watchdog abort.
module f_add_resp_checker #(
    parameter int NUM_VECTORS = 8,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_valid,
    input  logic             a,
    input  logic             b,
    input  logic             cin,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timed_out,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [WD_W-1:0] wd_cnt;
    logic            mismatch;
    logic            accept;
    logic            last_vec;
    logic            wd_expire;
    logic            run_start;
    logic [1:0]      golden;

    // Returns {carry, sum} of a full adder.
    function automatic logic [1:0] golden_fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign golden    = golden_fa(a, b, cin);
    assign mismatch  = (sum != golden[0]) || (carry != golden[1]);
    assign accept    = (state == RUN) && vec_valid;
    assign last_vec  = accept && (vec_cnt == CNT_W'(NUM_VECTORS - 1));
    assign wd_expire = (state == RUN) && !vec_valid && (wd_cnt == WD_W'(TIMEOUT - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_start = 1'b1;
                end
            end
            RUN: begin
                if (last_vec || wd_expire) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Statistics and verdict; the final vector's own mismatch is folded into pass here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_cnt         <= '0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            timed_out       <= 1'b0;
            wd_cnt          <= '0;
        end else if (run_start) begin
            vec_cnt         <= '0;
            err_cnt         <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            timed_out       <= 1'b0;
            wd_cnt          <= '0;
        end else if (accept) begin
            vec_cnt <= vec_cnt + CNT_W'(1);
            wd_cnt  <= '0;
            if (mismatch) begin
                err_cnt <= sat_inc(err_cnt);
                if (!first_err_valid) begin
                    first_err_vec   <= {a, b, cin};
                    first_err_valid <= 1'b1;
                end
            end
            if (last_vec) begin
                pass <= !mismatch && (err_cnt == '0);
            end
        end else if (wd_expire) begin
            timed_out <= 1'b1;
            pass      <= 1'b0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule
